// File: rtl/program_loader.sv
// Framed byte-stream loader for the CPU instruction memory: SYNC, BASE, LEN, data, CHK.
// Optional inter-byte timeout is enabled by defining LOADER_TIMEOUT_EN.
module program_loader #(
  parameter int         ADDR_W         = 8,
  parameter int         MEM_DEPTH      = 256,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              load_done,
  output logic              load_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_BASE,
    S_LEN,
    S_DATA,
    S_CHK,
    S_DONE,
    S_ERR
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] ptr;
  logic [7:0]        remaining;
  logic [7:0]        sum;
  logic [7:0]        chk_sum;
  logic              accept;
  logic              len_bad;

  assign accept = in_valid & in_ready;

  // Kept at 8 bits so the checksum wraps mod 256 before the zero test.
  always_comb begin
    chk_sum = sum + in_data;
    len_bad = (in_data == 8'h00) || (32'(in_data) > 32'(MEM_DEPTH));
  end

  if (MEM_DEPTH != 2 ** ADDR_W || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("program_loader: MEM_DEPTH must equal 2**ADDR_W and TIMEOUT_CYCLES must be >= 1");
  end

`ifdef LOADER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
  logic            frame_active;

  always_comb begin
    frame_active = (state == S_BASE) || (state == S_LEN) ||
                   (state == S_DATA) || (state == S_CHK);
  end
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      cpu_hold   <= 1'b0;
      busy       <= 1'b0;
      load_done  <= 1'b0;
      load_error <= 1'b0;
      ptr        <= '0;
      remaining  <= '0;
      sum        <= '0;
`ifdef LOADER_TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      imem_we   <= 1'b0;
      load_done <= 1'b0;
      in_ready  <= 1'b1;

      case (state)
        S_IDLE, S_ERR: begin
          if (accept && in_data == SYNC_BYTE) begin
            state      <= S_BASE;
            busy       <= 1'b1;
            cpu_hold   <= 1'b1;
            load_error <= 1'b0;
          end
        end

        S_BASE: begin
          if (accept) begin
            ptr   <= ADDR_W'(in_data);
            sum   <= in_data;
            state <= S_LEN;
          end
        end

        S_LEN: begin
          if (accept) begin
            sum <= chk_sum;
            if (len_bad) begin
              state      <= S_ERR;
              load_error <= 1'b1;
              busy       <= 1'b0;
            end else begin
              remaining <= in_data;
              state     <= S_DATA;
            end
          end
        end

        S_DATA: begin
          if (accept) begin
            imem_we    <= 1'b1;
            imem_addr  <= ptr;
            imem_wdata <= in_data;
            ptr        <= ptr + 1'b1;
            sum        <= chk_sum;
            remaining  <= remaining - 1'b1;
            if (remaining == 8'd1) begin
              state <= S_CHK;
            end
          end
        end

        S_CHK: begin
          if (accept) begin
            if (chk_sum == 8'h00) begin
              state     <= S_DONE;
              load_done <= 1'b1;
              cpu_hold  <= 1'b0;
              busy      <= 1'b0;
              in_ready  <= 1'b0;
            end else begin
              state      <= S_ERR;
              load_error <= 1'b1;
              busy       <= 1'b0;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase

`ifdef LOADER_TIMEOUT_EN
      // Only a stall with no accept can time out, so this never races a frame transition.
      if (!frame_active || accept) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        to_cnt     <= '0;
        state      <= S_ERR;
        load_error <= 1'b1;
        busy       <= 1'b0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed and random frames against a frame-level model.
module tb_program_loader;

  localparam int TO_CYC = `ifdef LOADER_TIMEOUT_EN 16 `else 1024 `endif;

  logic       clk;
  logic       reset;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic       imem_we;
  logic [7:0] imem_addr;
  logic [7:0] imem_wdata;
  logic       cpu_hold;
  logic       busy;
  logic       load_done;
  logic       load_error;

  program_loader #(
    .ADDR_W        (8),
    .MEM_DEPTH     (256),
    .SYNC_BYTE     (8'hA5),
    .TIMEOUT_CYCLES(TO_CYC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .cpu_hold  (cpu_hold),
    .busy      (busy),
    .load_done (load_done),
    .load_error(load_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Output monitor, sampled on the falling edge
  bit mon_en = 1'b0;
  int w_addr[$];
  int w_data[$];
  int w_cyc[$];
  int done_cnt;
  int bad_done;

  always @(negedge clk) begin
    if (mon_en) begin
      if (imem_we === 1'b1) begin
        w_addr.push_back(int'(imem_addr));
        w_data.push_back(int'(imem_wdata));
        w_cyc.push_back(cyc);
      end
      if (load_done === 1'b1) begin
        done_cnt++;
        if (cpu_hold !== 1'b0 || busy !== 1'b0) bad_done++;
      end
    end
  end

  logic [7:0] stim[$];
  int         acc_cyc[512];
  int         exp_addr[$];
  int         exp_data[$];
  int         exp_idx[$];

  // Frame-level reference: walks the byte list by the frame format and checksum rule
  task automatic model(output int e_done, output bit e_err);
    int i;
    int base;
    int len;
    int s;
    bit err;
    exp_addr.delete();
    exp_data.delete();
    exp_idx.delete();
    e_done = 0;
    err    = 1'b0;
    i      = 0;
    while (i < stim.size()) begin
      if (stim[i] != 8'hA5) begin
        i++;
        continue;
      end
      base = int'(stim[i+1]);
      len  = int'(stim[i+2]);
      if (len == 0) begin
        err = 1'b1;
        i += 3;
        continue;
      end
      s = base + len;
      for (int k = 0; k < len; k++) begin
        exp_addr.push_back((base + k) % 256);
        exp_data.push_back(int'(stim[i+3+k]));
        exp_idx.push_back(i + 3 + k);
        s += int'(stim[i+3+k]);
      end
      s += int'(stim[i+3+len]);
      if (s % 256 == 0) begin
        e_done++;
        err = 1'b0;
      end else begin
        err = 1'b1;
      end
      i += 4 + len;
    end
    e_err = err;
  endtask

  task automatic send_byte(input int idx, input logic [7:0] b, input bit rnd);
    int guard;
    bit sent;
    guard = 0;
    sent  = 1'b0;
    while (!sent) begin
      @(negedge clk);
      in_valid = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = in_valid ? b : 8'($urandom);
      if (in_valid && in_ready) begin
        acc_cyc[idx] = cyc;
        sent = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
      end else begin
        guard++;
        if (guard > 100) begin
          check("accept_timeout", 32'd0, 32'd1);
          sent = 1'b1;
        end
      end
    end
  endtask

  task automatic run_stream(input string tag, input bit rnd);
    int  e_done;
    bit  e_err;
    int  n;
    w_addr.delete();
    w_data.delete();
    w_cyc.delete();
    done_cnt = 0;
    bad_done = 0;
    mon_en   = 1'b1;
    for (int idx = 0; idx < stim.size(); idx++) send_byte(idx, stim[idx], rnd);
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    model(e_done, e_err);
    check({tag, "_nwrites"}, w_addr.size(), exp_addr.size());
    n = (w_addr.size() < exp_addr.size()) ? w_addr.size() : exp_addr.size();
    for (int k = 0; k < n; k++) begin
      check({tag, "_waddr"}, w_addr[k], exp_addr[k]);
      check({tag, "_wdata"}, w_data[k], exp_data[k]);
      check({tag, "_wlat"}, w_cyc[k], acc_cyc[exp_idx[k]] + 1);
    end
    check({tag, "_done_cnt"}, done_cnt, e_done);
    check({tag, "_done_flags"}, bad_done, 0);
    check({tag, "_load_error"}, load_error, e_err);
    check({tag, "_cpu_hold"}, cpu_hold, e_err);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, in_ready, 1'b0);
    check({tag, "_imem_we"}, imem_we, 1'b0);
    check({tag, "_imem_addr"}, imem_addr, 8'h00);
    check({tag, "_imem_wdata"}, imem_wdata, 8'h00);
    check({tag, "_cpu_hold"}, cpu_hold, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_load_done"}, load_done, 1'b0);
    check({tag, "_load_error"}, load_error, 1'b0);
  endtask

  task automatic push_frame(input logic [7:0] base, input int len, input bit good);
    int s;
    logic [7:0] d;
    stim.push_back(8'hA5);
    stim.push_back(base);
    stim.push_back(8'(len));
    s = int'(base) + len;
    for (int k = 0; k < len; k++) begin
      d = 8'($urandom);
      stim.push_back(d);
      s += int'(d);
    end
    stim.push_back(8'((256 - (s % 256)) % 256 + (good ? 0 : 1)));
  endtask

  initial begin
    int c0;
    int guard;
    logic [7:0] g;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = 8'h00;

    #12 check_reset_values("por");
    @(negedge clk) reset = 1'b0;
    #1 check("first_cycle_in_ready", in_ready, 1'b0);
    @(posedge clk);
    #1 check("ready_after_release", in_ready, 1'b1);

    stim = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    run_stream("normal", 1'b0);

    stim = '{8'hA5, 8'hFE, 8'h03, 8'h01, 8'h02, 8'h03, 8'hF9};
    run_stream("wrap", 1'b0);

    stim = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h88};
    run_stream("badchk", 1'b0);

    stim = '{8'hA5, 8'h00, 8'h01, 8'h5A, 8'hA5};
    run_stream("recover", 1'b0);

    stim = '{8'hA5, 8'h20, 8'h00};
    run_stream("len0", 1'b0);

    stim = '{8'h00, 8'hFF, 8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    run_stream("backpressure", 1'b1);

    for (int r = 0; r < 4; r++) begin
      stim.delete();
      for (int f = 0; f < 3; f++) begin
        g = 8'($urandom);
        if (g == 8'hA5) g = 8'h00;
        stim.push_back(g);
        push_frame(8'($urandom), int'($urandom_range(1, 6)), $urandom_range(0, 3) != 0);
      end
      run_stream("random", 1'b1);
    end

    stim = '{8'hA5, 8'h10, 8'h03, 8'h11};
    for (int idx = 0; idx < stim.size(); idx++) send_byte(idx, stim[idx], 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("mid_reset");
    @(negedge clk) reset = 1'b0;
    #1 check("mid_reset_ready_low", in_ready, 1'b0);
    stim = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    run_stream("after_reset", 1'b0);

`ifdef LOADER_TIMEOUT_EN
    stim = '{8'hA5, 8'h10};
    for (int idx = 0; idx < stim.size(); idx++) send_byte(idx, stim[idx], 1'b0);
    c0 = acc_cyc[1];
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (cyc < c0 + TO_CYC && guard < 100);
    check("timeout_not_yet", load_error, 1'b0);
    @(negedge clk);
    check("timeout_error", load_error, 1'b1);
    check("timeout_hold", cpu_hold, 1'b1);
    check("timeout_busy", busy, 1'b0);
`else
    c0    = 0;
    guard = 0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
